// File: rtl/mem_arbiter.sv
// mem_arbiter: serializes the fetch stage and the MEM stage of the 16-bit
// pipeline onto one single-port, fixed-latency unified memory.
// Data accesses win over fetch; there is no preemption once an access starts.
//
// Handshake: a requester raises its request level (if_req, or dm_re/dm_we)
// and holds it, with address/data stable, until it sees its one-cycle
// ready pulse; stall_* is high while a request is pending and ready is low.
//
// Optional feature: define MEM_ARB_IBUF_EN to add a one-entry fetch buffer
// {valid, tag, instruction} that lets a repeated fetch of the same address
// complete without a memory access.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // fetch port
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_ready,
  // data port
  input  logic              i_dm_re,
  input  logic              i_dm_we,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [DATA_W-1:0] i_dm_wdata,
  output logic [DATA_W-1:0] o_dm_rdata,
  output logic              o_dm_ready,
  // memory port
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_re,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  // pipeline stalls and FSM observation
  output logic              o_stall_if,
  output logic              o_stall_dm,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Counter reload value: the access occupies MEM_LAT busy cycles.
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_re;
  logic                r_mem_we;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_dm_rdata;
  logic                r_if_ready;
  logic                r_dm_ready;

  logic                w_dm_req;
  logic                w_cnt_zero;
  logic                w_ib_hit;
  logic [DATA_W-1:0]   w_ib_data;

  assign w_dm_req   = i_dm_re | i_dm_we;
  assign w_cnt_zero = (r_cnt == 4'd0);

`ifdef MEM_ARB_IBUF_EN
  logic                r_ib_valid;
  logic [ADDR_W-1:0]   r_ib_tag;
  logic [DATA_W-1:0]   r_ib_data;

  assign w_ib_hit  = r_ib_valid && (r_ib_tag == i_if_addr);
  assign w_ib_data = r_ib_data;

  // Fetch buffer: refilled by every memory fetch, invalidated by a granted
  // data write to the buffered address so it never returns stale code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ib_valid <= 1'b0;
      r_ib_tag   <= '0;
      r_ib_data  <= '0;
    end else if (r_state == BUSY_I && w_cnt_zero) begin
      r_ib_valid <= 1'b1;
      r_ib_tag   <= r_mem_addr;
      r_ib_data  <= i_mem_rdata;
    end else if (r_state == IDLE && i_dm_we && i_dm_addr == r_ib_tag) begin
      r_ib_valid <= 1'b0;
    end
  end
`else
  assign w_ib_hit  = 1'b0;
  assign w_ib_data = '0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic: data before fetch, no preemption, one DONE cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_dm_req)      w_next_state = BUSY_D;
        else if (i_if_req) w_next_state = w_ib_hit ? DONE : BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (w_cnt_zero) w_next_state = DONE;
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: latch the granted access, hold it for MEM_LAT cycles, capture
  // read data in the last busy cycle and raise the winner's ready pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 4'd0;
      r_mem_addr  <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_ready  <= 1'b0;
      r_dm_ready  <= 1'b0;
    end else begin
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_dm_req) begin
            // A write wins when both read and write are requested.
            r_mem_addr  <= i_dm_addr;
            r_mem_wdata <= i_dm_wdata;
            r_mem_we    <= i_dm_we;
            r_mem_re    <= ~i_dm_we;
            r_cnt       <= LAT_M1;
          end else if (i_if_req) begin
            if (w_ib_hit) begin
              r_if_rdata <= w_ib_data;
              r_if_ready <= 1'b1;
            end else begin
              r_mem_addr <= i_if_addr;
              r_mem_re   <= 1'b1;
              r_mem_we   <= 1'b0;
              r_cnt      <= LAT_M1;
            end
          end
        end
        BUSY_I: begin
          if (w_cnt_zero) begin
            r_if_rdata <= i_mem_rdata;
            r_mem_re   <= 1'b0;
            r_if_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        BUSY_D: begin
          if (w_cnt_zero) begin
            // Writes leave the previously read data untouched.
            if (r_mem_re) r_dm_rdata <= i_mem_rdata;
            r_mem_re   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_dm_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_if_rdata  = r_if_rdata;
  assign o_if_ready  = r_if_ready;
  assign o_dm_rdata  = r_dm_rdata;
  assign o_dm_ready  = r_dm_ready;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_re    = r_mem_re;
  assign o_mem_we    = r_mem_we;
  assign o_mem_wdata = r_mem_wdata;
  assign o_stall_if  = i_if_req & ~r_if_ready;
  assign o_stall_dm  = w_dm_req & ~r_dm_ready;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: fixed-latency memory model, driver tasks for
// the fetch and data ports, a ready-driven scoreboard and directed checks
// of latency, stall length and memory enable activity.
module tb_mem_arbiter;

  localparam int LAT = 4;
`ifdef MEM_ARB_IBUF_EN
  localparam int HIT_LAT = 1;
  localparam int HIT_MRE = 0;
`else
  localparam int HIT_LAT = LAT + 1;
  localparam int HIT_MRE = LAT;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        i_if_req = 1'b0;
  logic [15:0] i_if_addr = '0;
  logic [15:0] o_if_rdata;
  logic        o_if_ready;
  logic        i_dm_re = 1'b0;
  logic        i_dm_we = 1'b0;
  logic [15:0] i_dm_addr = '0;
  logic [15:0] i_dm_wdata = '0;
  logic [15:0] o_dm_rdata;
  logic        o_dm_ready;
  logic [15:0] o_mem_addr;
  logic        o_mem_re;
  logic        o_mem_we;
  logic [15:0] o_mem_wdata;
  logic [15:0] i_mem_rdata;
  logic        o_stall_if;
  logic        o_stall_dm;
  logic [1:0]  o_dbg_state;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_rdata(o_if_rdata), .o_if_ready(o_if_ready),
    .i_dm_re(i_dm_re), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr), .i_dm_wdata(i_dm_wdata),
    .o_dm_rdata(o_dm_rdata), .o_dm_ready(o_dm_ready),
    .o_mem_addr(o_mem_addr), .o_mem_re(o_mem_re), .o_mem_we(o_mem_we),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
    .o_stall_if(o_stall_if), .o_stall_dm(o_stall_dm), .o_dbg_state(o_dbg_state)
  );

  // ---------------- memory model ----------------
  // Data is only valid in the last busy cycle; otherwise a poison value.
  logic [15:0] mem_arr [0:65535];
  int busy_cyc = 0;
  always @(posedge clk) begin
    if (o_mem_re || o_mem_we) busy_cyc <= busy_cyc + 1;
    else                      busy_cyc <= 0;
  end
  always @(posedge clk) begin
    if (o_mem_we && busy_cyc == LAT - 1) mem_arr[o_mem_addr] <= o_mem_wdata;
  end
  assign i_mem_rdata = (o_mem_re && busy_cyc == LAT - 1) ? mem_arr[o_mem_addr] : 16'hDEAD;

  // ---------------- activity counters ----------------
  int stall_if_cnt = 0, stall_dm_cnt = 0, mem_re_cnt = 0, mem_we_cnt = 0;
  always @(negedge clk) begin
    stall_if_cnt += int'(o_stall_if);
    stall_dm_cnt += int'(o_stall_dm);
    mem_re_cnt   += int'(o_mem_re);
    mem_we_cnt   += int'(o_mem_we);
  end

  task automatic clr_cnt();
    stall_if_cnt = 0; stall_dm_cnt = 0; mem_re_cnt = 0; mem_we_cnt = 0;
  endtask

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] if_exp_q[$];
  logic [15:0] dm_exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse pops and compares the expected read data.
  always @(negedge clk) begin
    if (rst_n && o_if_ready) begin
      if (if_exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL if_unexpected_ready: got rdata 0x%0h expected no pulse", o_if_rdata);
      end else begin
        check("if_rdata", int'(o_if_rdata), int'(if_exp_q.pop_front()));
      end
    end
    if (rst_n && o_dm_ready) begin
      if (dm_exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dm_unexpected_ready: got rdata 0x%0h expected no pulse", o_dm_rdata);
      end else begin
        check("dm_rdata", int'(o_dm_rdata), int'(dm_exp_q.pop_front()));
      end
    end
  end

  // ---------------- drivers ----------------
  // Both return the number of edges from request raise to the ready cycle.
  task automatic fetch(input logic [15:0] a, input logic [15:0] exp, output int lat);
    if_exp_q.push_back(exp);
    @(posedge clk); #1;
    i_if_req = 1'b1; i_if_addr = a; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!o_if_ready && lat < 40);
    i_if_req = 1'b0;
  endtask

  task automatic data(input logic re, input logic we, input logic [15:0] a,
                      input logic [15:0] wd, input logic [15:0] exp, output int lat);
    dm_exp_q.push_back(exp);
    @(posedge clk); #1;
    i_dm_re = re; i_dm_we = we; i_dm_addr = a; i_dm_wdata = wd; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!o_dm_ready && lat < 40);
    i_dm_re = 1'b0; i_dm_we = 1'b0;
  endtask

  // Directed read vectors with hand-computed contents.
  logic [15:0] rd_addr [3] = '{16'h1000, 16'hFFFF, 16'h0000};
  logic [15:0] rd_data [3] = '{16'h1111, 16'hF00F, 16'h5A5A};

  // ---------------- stimulus ----------------
  initial begin
    int ld, lf, lat;
    for (int i = 0; i < 65536; i++) mem_arr[i] = 16'(i) ^ 16'h5A5A;
    mem_arr[16'h0010] = 16'hB123;
    mem_arr[16'h8000] = 16'h00FF;
    mem_arr[16'h0020] = 16'h2222;
    mem_arr[16'h0030] = 16'h3C3C;
    mem_arr[16'h1000] = 16'h1111;
    mem_arr[16'hFFFF] = 16'hF00F;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_re",   int'(o_mem_re),    0);
    check("rst_mem_we",   int'(o_mem_we),    0);
    check("rst_if_ready", int'(o_if_ready),  0);
    check("rst_dm_ready", int'(o_dm_ready),  0);
    check("rst_if_rdata", int'(o_if_rdata),  0);
    check("rst_dm_rdata", int'(o_dm_rdata),  0);
    check("rst_mem_addr", int'(o_mem_addr),  0);
    check("rst_state",    int'(o_dbg_state), 0);
    @(negedge clk) rst_n = 1'b1;

    // Reset in the middle of a data write
    @(posedge clk); #1;
    i_dm_we = 1'b1; i_dm_addr = 16'h0050; i_dm_wdata = 16'h1234;
    @(posedge clk);
    @(posedge clk); #1;
    check("midrst_state_busy_d", int'(o_dbg_state), 2);
    check("midrst_mem_we_before", int'(o_mem_we), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_mem_we",    int'(o_mem_we),    0);
    check("midrst_dm_ready",  int'(o_dm_ready),  0);
    check("midrst_state",     int'(o_dbg_state), 0);
    check("midrst_mem_addr",  int'(o_mem_addr),  0);
    check("midrst_mem_wdata", int'(o_mem_wdata), 0);
    clr_cnt();
    dm_exp_q.push_back(16'h0000);
    @(negedge clk) rst_n = 1'b1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!o_dm_ready && lat < 40);
    i_dm_we = 1'b0;
    check("restart_lat",    lat, LAT + 1);
    check("restart_we_cyc", mem_we_cnt, LAT);
    data(1'b1, 1'b0, 16'h0050, 16'h0000, 16'h1234, ld);
    check("restart_readback_lat", ld, LAT + 1);

    // Single fetch
    clr_cnt();
    fetch(16'h0010, 16'hB123, lf);
    check("fetch_lat",       lf, LAT + 1);
    check("fetch_stall_cyc", stall_if_cnt, LAT + 1);
    check("fetch_re_cyc",    mem_re_cnt, LAT);
    check("fetch_we_cyc",    mem_we_cnt, 0);

    // Simultaneous fetch and data read: data first
    clr_cnt();
    fork
      data(1'b1, 1'b0, 16'h8000, 16'h0000, 16'h00FF, ld);
      fetch(16'h0020, 16'h2222, lf);
    join
    check("prio_dm_lat",    ld, LAT + 1);
    check("prio_if_lat",    lf, 2 * LAT + 3);
    check("prio_stall_if",  stall_if_cnt, 2 * LAT + 3);
    check("prio_stall_dm",  stall_dm_cnt, LAT + 1);
    check("prio_re_cyc",    mem_re_cnt, 2 * LAT);

    // Write with read also high: write wins, dm_rdata unchanged
    clr_cnt();
    data(1'b1, 1'b1, 16'h0040, 16'hA5A5, 16'h00FF, ld);
    check("wr_lat",    ld, LAT + 1);
    check("wr_we_cyc", mem_we_cnt, LAT);
    check("wr_re_cyc", mem_re_cnt, 0);
    clr_cnt();
    data(1'b1, 1'b0, 16'h0040, 16'h0000, 16'hA5A5, ld);
    check("wr_readback_lat", ld, LAT + 1);
    check("wr_readback_re",  mem_re_cnt, LAT);

    // Directed reads including address extremes
    for (int i = 0; i < 3; i++) begin
      data(1'b1, 1'b0, rd_addr[i], 16'h0000, rd_data[i], ld);
      check("tbl_rd_lat", ld, LAT + 1);
    end

    // Repeated fetch (buffered when the fetch buffer is built in)
    clr_cnt();
    fetch(16'h0030, 16'h3C3C, lf);
    check("ib_first_lat", lf, LAT + 1);
    clr_cnt();
    fetch(16'h0030, 16'h3C3C, lf);
    check("ib_hit_lat", lf, HIT_LAT);
    check("ib_hit_re",  mem_re_cnt, HIT_MRE);
    data(1'b0, 1'b1, 16'h0030, 16'h7777, 16'h5A5A, ld);
    check("ib_wr_lat", ld, LAT + 1);
    clr_cnt();
    fetch(16'h0030, 16'h7777, lf);
    check("ib_after_wr_lat", lf, LAT + 1);
    check("ib_after_wr_re",  mem_re_cnt, LAT);

    // Everything expected was delivered
    repeat (3) @(posedge clk);
    #1;
    check("if_queue_left", if_exp_q.size(), 0);
    check("dm_queue_left", dm_exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
